// File: rtl/injetor_seq_if.sv
// ============================================================================
// Module      : injetor_seq_if
// Description : Valid/ready word stream in and out of the error injector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface injetor_seq_if #(
    parameter int WIDTH = 9
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] entrada;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] saida;
    logic             erro_inj;

    // master drives the input stream and consumes the output stream
    modport master (
        output in_valid, entrada, out_ready,
        input  in_ready, out_valid, saida, erro_inj
    );

    modport slave (
        input  in_valid, entrada, out_ready,
        output in_ready, out_valid, saida, erro_inj
    );
endinterface

`default_nettype wire

// File: rtl/injetor_seq.sv
// ============================================================================
// Module      : injetor_seq
// Description : One-stage streaming injector of 1..8-bit adjacent flip bursts
//               with off / single-shot / periodic / walking-bit modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module injetor_seq #(
    parameter int WIDTH = 9,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    injetor_seq_if.slave          bus,
    input  wire logic [1:0]       modo,
    input  wire logic [POS_W-1:0] n,
    input  wire logic [2:0]       rajada,
    input  wire logic [7:0]       periodo,
    input  wire logic             disparo,
    output logic      [15:0]      contagem_erros
);

    localparam logic [1:0]       c_modo_off    = 2'd0;
    localparam logic [1:0]       c_modo_single = 2'd1;
    localparam logic [1:0]       c_modo_period = 2'd2;
    localparam logic [1:0]       c_modo_walk   = 2'd3;
    localparam logic [POS_W-1:0] c_pos_last    = POS_W'(WIDTH - 1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_saida;
    logic             r_erro_inj;
    logic [15:0]      r_contagem;
    logic             r_armado;
    logic [7:0]       r_fase;
    logic [POS_W-1:0] r_pos_walk;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_emit;
    logic [POS_W-1:0] w_pos;
    logic [6:0]       w_lo;
    logic [6:0]       w_hi;
    logic [WIDTH-1:0] w_mask;
    logic [7:0]       w_per_eff;
    logic             w_fase_hit;
    logic             w_sel;
    logic             w_corrupt;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_emit     = r_out_valid && bus.out_ready;

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.saida       = r_saida;
    assign bus.erro_inj    = r_erro_inj;
    assign contagem_erros  = r_contagem;

    // Burst spans [lo, hi]; bits past the top of the word simply fall off.
    assign w_pos = (modo == c_modo_walk) ? r_pos_walk : n;
    assign w_lo  = 7'(w_pos);
    assign w_hi  = w_lo + 7'(rajada);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((7'(i) >= w_lo) && (7'(i) <= w_hi)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    // A shrunken period that fase already exceeds fires on the next word.
    assign w_per_eff  = (periodo == 8'd0) ? 8'd1 : periodo;
    assign w_fase_hit = (r_fase >= (w_per_eff - 8'd1));

    always_comb begin
        w_sel = 1'b0;
        case (modo)
            c_modo_off:    w_sel = 1'b0;
            c_modo_single: w_sel = r_armado;
            c_modo_period: w_sel = w_fase_hit;
            c_modo_walk:   w_sel = 1'b1;
            default:       w_sel = 1'b0;
        endcase
    end

    assign w_corrupt = w_sel && (|w_mask);

    // Output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_saida     <= '0;
            r_erro_inj  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_saida     <= w_sel ? (bus.entrada ^ w_mask) : bus.entrada;
            r_erro_inj  <= w_corrupt;
        end else if (w_emit) begin
            r_out_valid <= 1'b0;
        end
    end

    // Counted at accept time, so the count leads the emit of the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contagem <= 16'd0;
        end else if (w_accept && w_corrupt && (r_contagem != 16'hFFFF)) begin
            r_contagem <= r_contagem + 16'd1;
        end
    end

    // A disparo in the same cycle as the consuming accept re-arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armado <= 1'b0;
        end else if (disparo) begin
            r_armado <= 1'b1;
        end else if (w_accept && (modo == c_modo_single)) begin
            r_armado <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fase <= 8'd0;
        end else if (w_accept) begin
            if ((modo == c_modo_period) && !w_fase_hit) begin
                r_fase <= r_fase + 8'd1;
            end else begin
                r_fase <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_walk <= '0;
        end else if (w_accept && (modo == c_modo_walk)) begin
            r_pos_walk <= (r_pos_walk == c_pos_last) ? '0 : r_pos_walk + 1'b1;
        end
    end

endmodule

`default_nettype wire
